rptr_level_ctrl: RTL and testbench
==================================

# rptr_level_ctrl

Parametrised read-side controller for the dual-clock FIFO. It keeps binary and Gray read pointers and generates registered empty and almost-empty flags. It also reports occupancy by decoding the write pointer (Gray, crossed from the write domain) back to binary, and records read-underflow attempts in a sticky flag. It sits in the read clock domain between the FIFO memory read port and the consumer.

## Interface
- PTR_WIDTH, 3, address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits
- AE_RESET, 1, reset value loaded into the almost-empty threshold shadow register

- i_Rclk  in  1  read-domain clock
- i_Rrst_n  in  1  reset, asynchronous, active-low
- i_R_en  in  1  read request from consumer
- i_g_wptr  in  PTR_WIDTH+1  Gray write pointer (pre-synchronised, or raw if RPTR_SYNC_EN)
- i_ae_thresh  in  PTR_WIDTH+1  almost-empty threshold, sampled only while o_empty=1
- i_clr_err  in  1  clears sticky underflow
- o_b_rptr  out  PTR_WIDTH+1  binary read pointer
- o_g_rptr  out  PTR_WIDTH+1  Gray read pointer, to write domain
- o_raddr  out  PTR_WIDTH  memory read address = o_b_rptr[PTR_WIDTH-1:0]
- o_empty  out  1  FIFO empty
- o_almost_empty  out  1  level <= threshold
- o_rlevel  out  PTR_WIDTH+1  entries available, 0..2**PTR_WIDTH
- o_rvalid  out  1  read data valid (one cycle after accepted read)
- o_underflow  out  1  sticky: read requested while empty

## Operation
- Accepted read: acc = i_R_en & !o_empty. b_next = o_b_rptr + acc, modulo 2**(PTR_WIDTH+1); g_next = b_next ^ (b_next >> 1).
- wsync = synchronised Gray write pointer; wbin = Gray-to-binary(wsync), XOR prefix from the MSB.
- Empty: o_empty <= (wsync == g_next).
- Level: lvl_next = wbin - b_next, modulo 2**(PTR_WIDTH+1). Register lvl_next into o_rlevel.
- Almost-empty: o_almost_empty <= (lvl_next <= thr). thr is a shadow register.
  - thr loads i_ae_thresh on every cycle where o_empty=1.
  - A threshold >= 2**PTR_WIDTH holds o_almost_empty at 1 permanently.
- o_rvalid <= acc.
- Underflow: set when i_R_en & o_empty; cleared by i_clr_err. Set wins if both occur in the same cycle.
- Wrap-around: pointer MSB toggles every 2**PTR_WIDTH reads. Level arithmetic stays correct across the wrap.
- Reset values (asynchronous): o_b_rptr=0, o_g_rptr=0, o_empty=1, o_almost_empty=1, o_rlevel=0, o_rvalid=0, o_underflow=0, thr=AE_RESET, synchroniser flops=0. Reset mid-operation discards all state immediately.
- Flags are pessimistic: empty/almost-empty may assert late-deasserted, never early-deasserted. o_rlevel never over-reports.

## Timing
- Accepted read at edge N: o_b_rptr, o_g_rptr, o_raddr update at N+1, and o_rvalid=1 during cycle N+1.
- Last entry read at edge N: o_empty=1 from N+1. No second read is accepted.
- A write-pointer change visible on wsync at edge N clears o_empty and updates o_rlevel at N+1.
- With RPTR_SYNC_EN, add 2 i_Rclk cycles from a change on i_g_wptr to wsync.
- Read and write-pointer advance in the same cycle: level is unchanged. o_empty follows the comparison with g_next.

## Configuration
- RPTR_SYNC_EN defined:
  - i_g_wptr is the raw write-domain Gray pointer.
  - Passes through an internal 2-flop synchroniser clocked by i_Rclk and reset by i_Rrst_n.
- RPTR_SYNC_EN undefined:
  - i_g_wptr is already synchronised; wsync = i_g_wptr.
  - No extra latency.

## Structure
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parametrised by width
  - default PTR_WIDTH constant
  - ptr_t typedef, PTR_WIDTH+1 bits
- Sub-module sync_2ff (parametrised width, asynchronous active-low reset), instantiated only under RPTR_SYNC_EN.

## Test plan
- Reset release, PTR_WIDTH=3, i_g_wptr=0 -> o_empty=1, o_almost_empty=1, o_rlevel=0, pointers 0, o_underflow=0.
- i_g_wptr=Gray(5)=4'b0111, then 5 reads -> o_rlevel 5,4,3,2,1,0. o_empty=1 after the 5th read; o_b_rptr=5, o_g_rptr=4'b0111.
- i_ae_thresh=2 loaded while empty, then i_g_wptr=Gray(4) -> o_almost_empty=0 at level 4,3. Reasserts when level reaches 2.
- Read while empty -> o_b_rptr unchanged, o_rvalid=0, o_underflow=1 and held. i_clr_err together with i_R_en while empty -> stays 1. i_clr_err alone -> 0.
- Wrap: drive wptr through 0..15 with continuous reads -> o_b_rptr wraps 15->0, o_raddr wraps 7->0, o_rlevel never exceeds 8.
- RPTR_SYNC_EN: step i_g_wptr 0->1 -> o_empty falls exactly 3 cycles later. Asserting i_Rrst_n low mid-stream returns all outputs to reset values without waiting for a clock.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: Gray/binary conversion and pointer type.
package fifo_pkg;

  localparam int unsigned DEF_PTR_WIDTH = 3;

  typedef logic [DEF_PTR_WIDTH:0] ptr_t;

  // Operands are zero-extended to 32 bits; w selects the live pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] b;
    b = '0;
    b[31] = (w >= 32) ? g[31] : 1'b0;
    for (int i = 30; i >= 0; i--) begin
      b[i] = (i < int'(w)) ? (g[i] ^ b[i+1]) : 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into the local clock domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      o_q    <= '0;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/rptr_level_ctrl.sv
// Read-side FIFO controller: read pointers, empty/almost-empty flags, level and underflow.
// Define RPTR_SYNC_EN to synchronise the raw write-domain Gray pointer internally.
module rptr_level_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int unsigned AE_RESET  = 1
) (
  input  logic               i_Rclk,
  input  logic               i_Rrst_n,
  input  logic               i_R_en,
  input  logic [PTR_WIDTH:0] i_g_wptr,
  input  logic [PTR_WIDTH:0] i_ae_thresh,
  input  logic               i_clr_err,
  output logic [PTR_WIDTH:0] o_b_rptr,
  output logic [PTR_WIDTH:0] o_g_rptr,
  output logic [PTR_WIDTH-1:0] o_raddr,
  output logic               o_empty,
  output logic               o_almost_empty,
  output logic [PTR_WIDTH:0] o_rlevel,
  output logic               o_rvalid,
  output logic               o_underflow
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] wsync;
  logic [PTR_WIDTH:0] wbin;
  logic [PTR_WIDTH:0] b_next;
  logic [PTR_WIDTH:0] g_next;
  logic [PTR_WIDTH:0] lvl_next;
  logic [PTR_WIDTH:0] thr_q;
  logic               acc;

`ifdef RPTR_SYNC_EN
  sync_2ff #(
    .WIDTH (PW)
  ) u_wptr_sync (
    .i_clk   (i_Rclk),
    .i_rst_n (i_Rrst_n),
    .i_d     (i_g_wptr),
    .o_q     (wsync)
  );
`else
  assign wsync = i_g_wptr;
`endif

  always_comb begin
    acc      = i_R_en & ~o_empty;
    b_next   = o_b_rptr + {{PTR_WIDTH{1'b0}}, acc};
    g_next   = PW'(bin2gray(32'(b_next), PW));
    wbin     = PW'(gray2bin(32'(wsync), PW));
    // Modular subtraction keeps the level correct across the pointer MSB wrap.
    lvl_next = wbin - b_next;
  end

  assign o_raddr = o_b_rptr[PTR_WIDTH-1:0];

  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      o_b_rptr       <= '0;
      o_g_rptr       <= '0;
      o_empty        <= 1'b1;
      o_almost_empty <= 1'b1;
      o_rlevel       <= '0;
      o_rvalid       <= 1'b0;
      o_underflow    <= 1'b0;
      thr_q          <= PW'(AE_RESET);
    end else begin
      o_b_rptr       <= b_next;
      o_g_rptr       <= g_next;
      o_empty        <= (wsync == g_next);
      o_rlevel       <= lvl_next;
      o_almost_empty <= (lvl_next <= thr_q);
      o_rvalid       <= acc;
      // Threshold only changes while nothing is buffered, so the flag never glitches.
      if (o_empty) begin
        thr_q <= i_ae_thresh;
      end
      if (i_R_en & o_empty) begin
        o_underflow <= 1'b1;
      end else if (i_clr_err) begin
        o_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_level_ctrl.sv
// Self-checking bench for rptr_level_ctrl: count-based scoreboard model plus vector table.
module tb_rptr_level_ctrl;

  logic       i_Rclk = 1'b0;
  logic       i_Rrst_n;
  logic       i_R_en;
  logic [3:0] i_g_wptr;
  logic [3:0] i_ae_thresh;
  logic       i_clr_err;
  logic [3:0] o_b_rptr;
  logic [3:0] o_g_rptr;
  logic [2:0] o_raddr;
  logic       o_empty;
  logic       o_almost_empty;
  logic [3:0] o_rlevel;
  logic       o_rvalid;
  logic       o_underflow;

  rptr_level_ctrl #(
    .PTR_WIDTH (3),
    .AE_RESET  (1)
  ) dut (
    .i_Rclk         (i_Rclk),
    .i_Rrst_n       (i_Rrst_n),
    .i_R_en         (i_R_en),
    .i_g_wptr       (i_g_wptr),
    .i_ae_thresh    (i_ae_thresh),
    .i_clr_err      (i_clr_err),
    .o_b_rptr       (o_b_rptr),
    .o_g_rptr       (o_g_rptr),
    .o_raddr        (o_raddr),
    .o_empty        (o_empty),
    .o_almost_empty (o_almost_empty),
    .o_rlevel       (o_rlevel),
    .o_rvalid       (o_rvalid),
    .o_underflow    (o_underflow)
  );

  always #5 i_Rclk = ~i_Rclk;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic [2:0] raddr;
    logic       empty;
    logic       ae;
    logic [3:0] lvl;
    logic       rvalid;
    logic       uf;
  } exp_t;

  typedef struct {
    bit         r_en;
    int         w;
    logic [3:0] thr;
    bit         clr;
    int         e_lvl;
    bit         e_empty;
    bit         e_ae;
    bit         e_uf;
    int         e_b;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[17];

  int n_vec = 0;
  int n_err = 0;

  // Model state: unbounded read/write counts, not wrapped pointers.
  int         m_rd;
  int         m_s1;
  int         m_s2;
  int         m_thr;
  bit         m_empty;
  bit         m_uf;
  int         wtot;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic model_reset();
    m_rd = 0; m_s1 = 0; m_s2 = 0; m_thr = 1; m_empty = 1'b1; m_uf = 1'b0; wtot = 0;
  endtask

  task automatic apply(input bit r, input int w, input logic [3:0] th, input bit c);
    exp_t e;
    int   wvis;
    int   lvl;
    bit   acc;
    i_R_en = r; i_g_wptr = gray4(w); i_ae_thresh = th; i_clr_err = c;
`ifdef RPTR_SYNC_EN
    wvis = m_s2;
`else
    wvis = w;
`endif
    acc  = r && !m_empty;
    m_rd = m_rd + int'(acc);
    lvl  = wvis - m_rd;
    e.empty  = (lvl == 0);
    e.ae     = (lvl <= m_thr);
    e.lvl    = lvl[3:0];
    e.rvalid = acc;
    if (r && m_empty) m_uf = 1'b1;
    else if (c) m_uf = 1'b0;
    e.uf = m_uf;
    if (m_empty) m_thr = int'(th);
    m_empty = e.empty;
    e.b     = m_rd[3:0];
    e.g     = gray4(m_rd);
    e.raddr = m_rd[2:0];
    m_s2 = m_s1; m_s1 = w;
    wtot = w;
    sb.push_back(e);
    @(posedge i_Rclk);
    #2;
    e = sb.pop_front();
    n_vec++;
    if ({o_b_rptr, o_g_rptr, o_raddr, o_empty, o_almost_empty, o_rlevel, o_rvalid, o_underflow}
        !== {e.b, e.g, e.raddr, e.empty, e.ae, e.lvl, e.rvalid, e.uf}) begin
      n_err++;
      $display("FAIL model t=%0t: got b=%0d g=%b ra=%0d e=%b ae=%b lvl=%0d rv=%b uf=%b, need b=%0d g=%b ra=%0d e=%b ae=%b lvl=%0d rv=%b uf=%b",
               $time, o_b_rptr, o_g_rptr, o_raddr, o_empty, o_almost_empty, o_rlevel, o_rvalid,
               o_underflow, e.b, e.g, e.raddr, e.empty, e.ae, e.lvl, e.rvalid, e.uf);
    end
  endtask

  task automatic check_reset_state(input string name);
    n_vec++;
    if ({o_b_rptr, o_g_rptr, o_raddr, o_empty, o_almost_empty, o_rlevel, o_rvalid, o_underflow}
        !== {4'd0, 4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: got b=%0d g=%b ra=%0d e=%b ae=%b lvl=%0d rv=%b uf=%b, need 0 0000 0 1 1 0 0 0",
               name, o_b_rptr, o_g_rptr, o_raddr, o_empty, o_almost_empty, o_rlevel, o_rvalid,
               o_underflow);
    end
  endtask

  initial begin
    //              r  w  thr  clr lvl emp ae uf b
    tbl[0]  = '{1'b0, 5, 4'd2, 1'b0, 5, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 5, 4'd2, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{1'b1, 5, 4'd2, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2};
    tbl[3]  = '{1'b1, 5, 4'd2, 1'b0, 2, 1'b0, 1'b1, 1'b0, 3};
    tbl[4]  = '{1'b1, 5, 4'd2, 1'b0, 1, 1'b0, 1'b1, 1'b0, 4};
    tbl[5]  = '{1'b1, 5, 4'd2, 1'b0, 0, 1'b1, 1'b1, 1'b0, 5};
    tbl[6]  = '{1'b1, 5, 4'd2, 1'b0, 0, 1'b1, 1'b1, 1'b1, 5};
    tbl[7]  = '{1'b1, 5, 4'd2, 1'b1, 0, 1'b1, 1'b1, 1'b1, 5};
    tbl[8]  = '{1'b0, 5, 4'd2, 1'b1, 0, 1'b1, 1'b1, 1'b0, 5};
    tbl[9]  = '{1'b0, 9, 4'd2, 1'b0, 4, 1'b0, 1'b0, 1'b0, 5};
    tbl[10] = '{1'b1, 9, 4'd2, 1'b0, 3, 1'b0, 1'b0, 1'b0, 6};
    tbl[11] = '{1'b1, 9, 4'd2, 1'b0, 2, 1'b0, 1'b1, 1'b0, 7};
    tbl[12] = '{1'b1, 9, 4'd2, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8};
    tbl[13] = '{1'b1, 9, 4'd2, 1'b0, 0, 1'b1, 1'b1, 1'b0, 9};
    tbl[14] = '{1'b0, 9, 4'd8, 1'b0, 0, 1'b1, 1'b1, 1'b0, 9};
    tbl[15] = '{1'b0, 17, 4'd8, 1'b0, 8, 1'b0, 1'b1, 1'b0, 9};
    tbl[16] = '{1'b1, 18, 4'd8, 1'b0, 8, 1'b0, 1'b1, 1'b0, 10};

    i_Rrst_n = 1'b0; i_R_en = 1'b0; i_g_wptr = '0; i_ae_thresh = '0; i_clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge i_Rclk);
    #2 i_Rrst_n = 1'b1;
    #1 check_reset_state("reset_release");

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].r_en, tbl[i].w, tbl[i].thr, tbl[i].clr);
`ifndef RPTR_SYNC_EN
      n_vec++;
      if (int'(o_rlevel) != tbl[i].e_lvl || o_empty != tbl[i].e_empty ||
          o_almost_empty != tbl[i].e_ae || o_underflow != tbl[i].e_uf ||
          int'(o_b_rptr) != tbl[i].e_b) begin
        n_err++;
        $display("FAIL table[%0d]: got lvl=%0d e=%b ae=%b uf=%b b=%0d, need lvl=%0d e=%b ae=%b uf=%b b=%0d",
                 i, o_rlevel, o_empty, o_almost_empty, o_underflow, o_b_rptr, tbl[i].e_lvl,
                 tbl[i].e_empty, tbl[i].e_ae, tbl[i].e_uf, tbl[i].e_b);
      end
`endif
    end

    // Continuous reads with the writer pacing ahead: pointers wrap several times.
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, ((wtot - m_rd) < 8) ? wtot + 1 : wtot, 4'd3, 1'b0);
      if (o_rlevel > 4'd8) begin
        n_err++;
        $display("FAIL wrap_level: got lvl=%0d, need <= 8", o_rlevel);
      end
    end

    for (int i = 0; i < 60; i++) begin
      int adv;
      adv = $urandom_range(0, 2);
      if (wtot - m_rd + adv > 8) adv = 0;
      apply(1'($urandom_range(0, 1)), wtot + adv, 4'($urandom_range(0, 9)),
            ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-stream must act without a clock edge.
    #1 i_Rrst_n = 1'b0;
    #1 check_reset_state("async_reset");
    i_R_en = 1'b0; i_g_wptr = '0; i_clr_err = 1'b0;
    model_reset();
    @(posedge i_Rclk);
    #2 i_Rrst_n = 1'b1;

`ifdef RPTR_SYNC_EN
    begin
      int lat;
      lat = 0;
      for (int i = 0; i < 10 && o_empty; i++) begin
        apply(1'b0, 1, 4'd1, 1'b0);
        lat++;
      end
      n_vec++;
      if (lat != 3) begin
        n_err++;
        $display("FAIL sync_latency: got %0d cycles, need 3", lat);
      end
    end
`endif
    for (int i = 0; i < 12; i++) apply(1'b1, (wtot < 8) ? wtot + 1 : wtot, 4'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
